// File: rtl/bpc_decomp_unpack.sv
// BPC decompression back end: collects DBX bit-planes into ping-pong banks,
// undoes the XOR chain, transposes planes into deltas and streams base+delta words.
module bpc_decomp_unpack #(
  parameter int WORD_W      = 16,
  parameter int BLOCK_WORDS = 64,
  parameter int LANES       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic [WORD_W-1:0]        in_base,
  input  logic [BLOCK_WORDS-2:0]   in_plane,
  input  logic                     in_xor,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [LANES*WORD_W-1:0]  out_data,
  output logic                     err
);

  localparam int PW     = BLOCK_WORDS - 1;
  localparam int NBEATS = BLOCK_WORDS / LANES;
  localparam int PCW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int BCW    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int IW     = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILL,
    BANK_FULL
  } bank_st_e;

  bank_st_e                          bank_st_q [2];
  bank_st_e                          bank_st_d [2];
  logic [1:0][WORD_W-1:0][PW-1:0]    planes_q, planes_d;
  logic [1:0][WORD_W-1:0]            base_q, base_d;
  logic                              wr_ptr_q, wr_ptr_d;
  logic                              rd_ptr_q, rd_ptr_d;
  logic [PCW-1:0]                    pcnt_q, pcnt_d;
  logic [BCW-1:0]                    beat_q, beat_d;
  logic                              err_q, err_d;
  logic                              in_fire, out_fire;
  logic [PW-1:0]                     prev_plane;

  assign in_ready   = (bank_st_q[wr_ptr_q] != BANK_FULL);
  assign out_valid  = (bank_st_q[rd_ptr_q] == BANK_FULL);
  assign in_fire    = in_valid & in_ready;
  assign out_fire   = out_valid & out_ready;
  assign prev_plane = planes_q[wr_ptr_q][pcnt_q - PCW'(1)];
  assign out_sop    = out_valid & (beat_q == '0);
  assign out_eop    = out_valid & (beat_q == BCW'(NBEATS - 1));
  assign err        = err_q;

  // Fill side writes only a non-FULL bank and drain side only the FULL one,
  // so both updates can land in the same cycle without touching the same bank.
  always_comb begin
    planes_d     = planes_q;
    base_d       = base_q;
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pcnt_d       = pcnt_q;
    beat_d       = beat_q;
    err_d        = 1'b0;

    if (in_fire) begin
      if (in_sop) begin
        if (bank_st_q[wr_ptr_q] == BANK_FILL) err_d = 1'b1;
        base_d[wr_ptr_q]      = in_base;
        planes_d[wr_ptr_q]    = '0;
        planes_d[wr_ptr_q][0] = in_plane;
        if (in_eop) begin
          bank_st_d[wr_ptr_q] = BANK_FULL;
          wr_ptr_d            = ~wr_ptr_q;
          pcnt_d              = '0;
        end else begin
          bank_st_d[wr_ptr_q] = BANK_FILL;
          pcnt_d              = PCW'(1);
        end
      end else if (bank_st_q[wr_ptr_q] == BANK_EMPTY) begin
        err_d = 1'b1;
      end else begin
        planes_d[wr_ptr_q][pcnt_q] = in_plane ^ (in_xor ? prev_plane : '0);
        if (in_eop || (pcnt_q == PCW'(WORD_W - 1))) begin
          for (int i = 0; i < WORD_W; i++) begin
            if (i > int'(pcnt_q)) planes_d[wr_ptr_q][i] = '0;
          end
          bank_st_d[wr_ptr_q] = BANK_FULL;
          wr_ptr_d            = ~wr_ptr_q;
          pcnt_d              = '0;
        end else begin
          pcnt_d = pcnt_q + PCW'(1);
        end
      end
    end

    if (out_fire) begin
      if (beat_q == BCW'(NBEATS - 1)) begin
        bank_st_d[rd_ptr_q] = BANK_EMPTY;
        planes_d[rd_ptr_q]  = '0;
        beat_d              = '0;
        rd_ptr_d            = ~rd_ptr_q;
      end else begin
        beat_d = beat_q + BCW'(1);
      end
    end
  end

  // Each lane transposes one column of the read bank; lane 0 lands in the MSBs.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IW-1:0]     widx, bitpos;
    logic [WORD_W-1:0] delta, word;

    always_comb begin
      widx   = IW'(beat_q) * IW'(LANES) + IW'(l);
      bitpos = (widx == '0) ? '0 : IW'(PW) - widx;
      delta  = '0;
      for (int p = 0; p < WORD_W; p++) begin
        delta[WORD_W-1-p] = planes_q[rd_ptr_q][p][bitpos];
      end
      word = (widx == '0) ? base_q[rd_ptr_q] : base_q[rd_ptr_q] + delta;
    end

    assign out_data[(LANES-1-l)*WORD_W +: WORD_W] = out_valid ? word : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0] <= BANK_EMPTY;
      bank_st_q[1] <= BANK_EMPTY;
      planes_q     <= '0;
      base_q       <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      pcnt_q       <= '0;
      beat_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      planes_q     <= planes_d;
      base_q       <= base_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pcnt_q       <= pcnt_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_bpc_decomp_unpack.sv
// Directed bench for bpc_decomp_unpack: fixed blocks with hand-derived output beats,
// covering backpressure, ping-pong banking, protocol errors and mid-output reset.
module tb_bpc_decomp_unpack;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sop;
   logic        in_eop;
   logic [15:0] in_base;
   logic [62:0] in_plane;
   logic        in_xor;
   logic        out_valid;
   logic        out_ready;
   logic        out_sop;
   logic        out_eop;
   logic [63:0] out_data;
   logic        err;

   int checks = 0;
   int passed = 0;
   int failed = 0;

   localparam logic [62:0] ONES  = {63{1'b1}};
   localparam logic [62:0] ZEROS = '0;

   bpc_decomp_unpack #(
      .WORD_W(16),
      .BLOCK_WORDS(64),
      .LANES(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_sop(in_sop),
      .in_eop(in_eop),
      .in_base(in_base),
      .in_plane(in_plane),
      .in_xor(in_xor),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sop(out_sop),
      .out_eop(out_eop),
      .out_data(out_data),
      .err(err)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Last-resort guard in case a handshake never completes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] simulation timeout");
   end

   // Single comparison point; every check in the bench funnels through here.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Presents one plane beat and holds it until accepted (bounded wait on in_ready).
   task automatic applyStimulus(input logic sop, input logic eop, input logic xr,
                                input logic [15:0] base, input logic [62:0] plane);
      int waitCycles = 0;
      in_valid = 1'b1;
      in_sop   = sop;
      in_eop   = eop;
      in_xor   = xr;
      in_base  = base;
      in_plane = plane;
      @(negedge clk);
      while (!in_ready && waitCycles < 200) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("inReadyWait", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sop   = 1'b0;
      in_eop   = 1'b0;
      in_xor   = 1'b0;
   endtask

   // Accepts one output beat and checks data and framing flags.
   task automatic expectBeat(input string tag, input int b, input logic [63:0] expData);
      int waitCycles = 0;
      out_ready = 1'b1;
      @(negedge clk);
      while (!out_valid && waitCycles < 200) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput($sformatf("%s_b%0d_valid", tag, b), out_valid, 1);
      checkOutput($sformatf("%s_b%0d_data", tag, b), out_data, expData);
      checkOutput($sformatf("%s_b%0d_sop", tag, b), out_sop, (b == 0) ? 1 : 0);
      checkOutput($sformatf("%s_b%0d_eop", tag, b), out_eop, (b == 15) ? 1 : 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drainBeats(input string tag, input int fromBeat, input int toBeat,
                             input logic [63:0] firstBeat, input logic [63:0] midBeat,
                             input logic [63:0] lastBeat);
      for (int b = fromBeat; b <= toBeat; b++) begin
         expectBeat(tag, b, (b == 0) ? firstBeat : ((b == 15) ? lastBeat : midBeat));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sop    = 1'b0;
      in_eop    = 1'b0;
      in_xor    = 1'b0;
      in_base   = '0;
      in_plane  = '0;
      out_ready = 1'b0;

      #12;
      checkOutput("rst_outValid", out_valid, 0);
      checkOutput("rst_outSop", out_sop, 0);
      checkOutput("rst_outEop", out_eop, 0);
      checkOutput("rst_outData", out_data, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_inReady", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] all-zero planes, base 0x1234");
      applyStimulus(1, 0, 0, 16'h1234, ZEROS);
      for (int i = 1; i < 16; i++) applyStimulus(0, 0, 0, 16'h0, ZEROS);
      checkOutput("zero_latency", out_valid, 1);
      drainBeats("zero", 0, 15, 64'h1234123412341234, 64'h1234123412341234,
                 64'h1234123412341234);
      out_ready = 1'b0;

      $display("[TB] LSB plane all ones, base 0");
      applyStimulus(1, 0, 0, 16'h0000, ZEROS);
      for (int i = 1; i < 15; i++) applyStimulus(0, 0, 0, 16'h0, ZEROS);
      applyStimulus(0, 0, 0, 16'h0, ONES);
      drainBeats("lsb", 0, 15, 64'h0000000100010001, 64'h0001000100010001,
                 64'h0001000100010001);
      out_ready = 1'b0;

      $display("[TB] XOR chain with early eop and wrap");
      applyStimulus(1, 0, 0, 16'h4000, ONES);
      applyStimulus(0, 1, 1, 16'h0, ZEROS);
      checkOutput("xor_latency", out_valid, 1);
      drainBeats("xor", 0, 15, 64'h4000000000000000, 64'h0, 64'h0);
      out_ready = 1'b0;

      $display("[TB] non-sop plane into empty bank");
      applyStimulus(0, 0, 0, 16'h0, ONES);
      checkOutput("orphan_err", err, 1);
      tick();
      checkOutput("orphan_errPulse", err, 0);
      checkOutput("orphan_noOutput", out_valid, 0);

      $display("[TB] restart after 5 planes");
      applyStimulus(1, 0, 0, 16'h5555, ONES);
      for (int i = 1; i < 5; i++) applyStimulus(0, 0, 0, 16'h0, ONES);
      checkOutput("restart_noErrYet", err, 0);
      applyStimulus(1, 0, 0, 16'h0001, 63'h4000000000000000);
      checkOutput("restart_err", err, 1);
      applyStimulus(0, 0, 0, 16'h0, ZEROS);
      checkOutput("restart_errPulse", err, 0);
      for (int i = 2; i < 15; i++) applyStimulus(0, 0, 0, 16'h0, ZEROS);
      applyStimulus(0, 0, 0, 16'h0, 63'h1);
      drainBeats("restart", 0, 15, 64'h0001800100010001, 64'h0001000100010001,
                 64'h0001000100010002);
      out_ready = 1'b0;

      $display("[TB] backpressure and ping-pong");
      applyStimulus(1, 0, 0, 16'h1111, ZEROS);
      for (int i = 1; i < 16; i++) applyStimulus(0, 0, 0, 16'h0, ZEROS);
      applyStimulus(1, 0, 0, 16'h2222, ZEROS);
      for (int i = 1; i < 15; i++) applyStimulus(0, 0, 0, 16'h0, ZEROS);
      applyStimulus(0, 0, 0, 16'h0, ONES);
      checkOutput("pp_bothFull_inReady", in_ready, 0);
      drainBeats("pp1", 0, 2, 64'h1111111111111111, 64'h1111111111111111,
                 64'h1111111111111111);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput($sformatf("pp_hold%0d_valid", c), out_valid, 1);
         checkOutput($sformatf("pp_hold%0d_data", c), out_data, 64'h1111111111111111);
         checkOutput($sformatf("pp_hold%0d_sop", c), out_sop, 0);
      end
      @(posedge clk);
      #1;
      drainBeats("pp1", 3, 14, 64'h1111111111111111, 64'h1111111111111111,
                 64'h1111111111111111);
      checkOutput("pp_preEop_inReady", in_ready, 0);
      drainBeats("pp1", 15, 15, 64'h1111111111111111, 64'h1111111111111111,
                 64'h1111111111111111);
      checkOutput("pp_postEop_inReady", in_ready, 1);
      out_ready = 1'b0;
      applyStimulus(1, 1, 0, 16'h3333, ZEROS);
      drainBeats("pp2", 0, 15, 64'h2222222322232223, 64'h2223222322232223,
                 64'h2223222322232223);
      drainBeats("pp3", 0, 15, 64'h3333333333333333, 64'h3333333333333333,
                 64'h3333333333333333);
      out_ready = 1'b0;

      $display("[TB] reset mid-output");
      applyStimulus(1, 0, 0, 16'h7777, ZEROS);
      for (int i = 1; i < 16; i++) applyStimulus(0, 0, 0, 16'h0, ZEROS);
      drainBeats("prerst", 0, 6, 64'h7777777777777777, 64'h7777777777777777,
                 64'h7777777777777777);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_outValid", out_valid, 0);
      checkOutput("midrst_inReady", in_ready, 1);
      checkOutput("midrst_outData", out_data, 0);
      checkOutput("midrst_outSop", out_sop, 0);
      out_ready = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1, 0, 0, 16'h0000, ZEROS);
      for (int i = 1; i < 15; i++) applyStimulus(0, 0, 0, 16'h0, ZEROS);
      applyStimulus(0, 0, 0, 16'h0, ONES);
      drainBeats("postrst", 0, 15, 64'h0000000100010001, 64'h0001000100010001,
                 64'h0001000100010001);
      out_ready = 1'b0;
      tick();
      checkOutput("final_idle", out_valid, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
